// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - opcode, ALU code and immediate-format definitions for decode
//
// Purpose: shared constants and helpers for the RV32I(+M) decode control stage.
// Contents: major opcodes, ALU op codes, immediate format enum, immediate builder,
//           funct3 -> base ALU op mapping.
package riscv_ctrl_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [4:0] ALU_AND     = 5'b00000;
  localparam logic [4:0] ALU_OR      = 5'b00001;
  localparam logic [4:0] ALU_ADD     = 5'b00010;
  localparam logic [4:0] ALU_SLL     = 5'b00011;
  localparam logic [4:0] ALU_SUB     = 5'b00100;
  localparam logic [4:0] ALU_SRL     = 5'b00101;
  localparam logic [4:0] ALU_SLTU    = 5'b00110;
  localparam logic [4:0] ALU_XOR     = 5'b00111;
  localparam logic [4:0] ALU_SLT     = 5'b01000;
  localparam logic [4:0] ALU_SRA     = 5'b01001;
  localparam logic [4:0] ALU_INVALID = 5'b01111;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  function automatic logic [31:0] gen_imm(input imm_fmt_e fmt, input logic [31:0] w);
    logic [31:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{w[31]}}, w[31:20]};
      IMM_S:   imm = {{20{w[31]}}, w[31:25], w[11:7]};
      IMM_B:   imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      IMM_U:   imm = {w[31:12], 12'h000};
      IMM_J:   imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: imm = 32'h0000_0000;
    endcase
    return imm;
  endfunction

  // Shared by OP and OP-IMM; the SUB/SRA variants are chosen by funct7 at the call site.
  function automatic logic [4:0] base_alu(input logic [2:0] funct3);
    logic [4:0] op;
    case (funct3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_ctrl_comb.sv
// rtl/decode_ctrl_comb.sv - combinational instruction word to control bundle decoder
//
// Purpose: decode one RV32I(+M) instruction word into ALU op, immediate and
//          datapath control flags. No state.
// Ports:
//   instr_i      32-bit instruction word
//   imm_o        sign-extended immediate (0 for R-type and unknown opcodes)
//   alu_ctrl_o   ALU op code (ALU_INVALID when illegal)
//   regwrite_o, imm_sel_o, mem_read_o, mem_write_o   datapath controls
//   mem_size_o   funct3 for loads/stores, else 0
//   branch_o, jump_o, lui_o, auipc_o                 flow / upper-immediate flags
//   illegal_o    instruction not decodable
module decode_ctrl_comb
  import riscv_ctrl_pkg::*;
#(
  parameter bit ENABLE_M = 1'b0
) (
  input  logic [31:0] instr_i,
  output logic [31:0] imm_o,
  output logic [4:0]  alu_ctrl_o,
  output logic        regwrite_o,
  output logic        imm_sel_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [2:0]  mem_size_o,
  output logic        branch_o,
  output logic        jump_o,
  output logic        lui_o,
  output logic        auipc_o,
  output logic        illegal_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign rd     = instr_i[11:7];

  imm_fmt_e   fmt;
  logic [4:0] alu;
  logic       rw, mr, mw, br, jp, ill;

  always_comb begin
    fmt        = IMM_NONE;
    alu        = ALU_INVALID;
    rw         = 1'b0;
    mr         = 1'b0;
    mw         = 1'b0;
    br         = 1'b0;
    jp         = 1'b0;
    ill        = 1'b0;
    imm_sel_o  = 1'b0;
    mem_size_o = 3'b000;
    lui_o      = 1'b0;
    auipc_o    = 1'b0;
    case (opcode)
      OPC_OP: begin
        rw = 1'b1;
        if (funct7 == 7'b0000000)                          alu = base_alu(funct3);
        else if (funct7 == 7'b0100000 && funct3 == 3'b000) alu = ALU_SUB;
        else if (funct7 == 7'b0100000 && funct3 == 3'b101) alu = ALU_SRA;
        else if (funct7 == 7'b0000001 && ENABLE_M)         alu = {2'b10, funct3};
        else                                               ill = 1'b1;
      end
      OPC_OP_IMM: begin
        fmt       = IMM_I;
        imm_sel_o = 1'b1;
        rw        = 1'b1;
        alu       = base_alu(funct3);
        // Only the shift-immediates carry a funct7 field; every other funct3 is a plain 12-bit immediate.
        if (funct3 == 3'b001 && funct7 != 7'b0000000) ill = 1'b1;
        if (funct3 == 3'b101) begin
          if (funct7[5])                     alu = ALU_SRA;
          else if (funct7 != 7'b0000000)     ill = 1'b1;
        end
      end
      OPC_LOAD: begin
        fmt        = IMM_I;
        imm_sel_o  = 1'b1;
        rw         = 1'b1;
        mr         = 1'b1;
        mem_size_o = funct3;
        alu        = ALU_ADD;
        ill        = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        fmt        = IMM_S;
        imm_sel_o  = 1'b1;
        mw         = 1'b1;
        mem_size_o = funct3;
        alu        = ALU_ADD;
        ill        = funct3[2] || (funct3 == 3'b011);
      end
      OPC_BRANCH: begin
        fmt = IMM_B;
        br  = 1'b1;
        alu = ALU_SUB;
        ill = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OPC_JAL: begin
        fmt       = IMM_J;
        imm_sel_o = 1'b1;
        jp        = 1'b1;
        rw        = 1'b1;
        alu       = ALU_ADD;
      end
      OPC_JALR: begin
        fmt       = IMM_I;
        imm_sel_o = 1'b1;
        jp        = 1'b1;
        rw        = 1'b1;
        alu       = ALU_ADD;
      end
      OPC_LUI: begin
        fmt       = IMM_U;
        imm_sel_o = 1'b1;
        rw        = 1'b1;
        lui_o     = 1'b1;
        alu       = ALU_ADD;
      end
      OPC_AUIPC: begin
        fmt       = IMM_U;
        imm_sel_o = 1'b1;
        rw        = 1'b1;
        auipc_o   = 1'b1;
        alu       = ALU_ADD;
      end
      default: ill = 1'b1;
    endcase
  end

  // An illegal word must not touch architectural state, so its side-effect flags are squashed here.
  assign imm_o       = gen_imm(fmt, instr_i);
  assign illegal_o   = ill;
  assign alu_ctrl_o  = ill ? ALU_INVALID : alu;
  assign regwrite_o  = rw & ~ill & (rd != 5'd0);
  assign mem_read_o  = mr & ~ill;
  assign mem_write_o = mw & ~ill;
  assign branch_o    = br & ~ill;
  assign jump_o      = jp & ~ill;

endmodule

// File: rtl/decode_ctrl_stage.sv
// rtl/decode_ctrl_stage.sv - registered RV32I(+M) decode control stage with handshake
//
// Purpose: accept one instruction per valid/ready handshake, decode it, and hold the
//          result in a single-entry output register with backpressure and flush.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   flush                  drop held entry and current input
//   in_valid/in_ready      upstream handshake; in_instr, in_pc inputs
//   out_valid/out_ready    downstream handshake
//   out_pc, out_rs1/rs2/rd, out_imm, out_alu_ctrl   decoded bundle
//   out_regwrite, out_imm_sel, out_mem_read, out_mem_write, out_mem_size
//   out_branch, out_jump, out_lui, out_auipc, out_illegal
//   illegal_cnt            saturating count of accepted illegal instructions
module decode_ctrl_stage #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [XLEN-1:0]  out_imm,
  output logic [4:0]       out_alu_ctrl,
  output logic             out_regwrite,
  output logic             out_imm_sel,
  output logic             out_mem_read,
  output logic             out_mem_write,
  output logic [2:0]       out_mem_size,
  output logic             out_branch,
  output logic             out_jump,
  output logic             out_lui,
  output logic             out_auipc,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);
  import riscv_ctrl_pkg::*;

  logic [31:0] imm_d;
  logic [4:0]  alu_d;
  logic        regwrite_d, imm_sel_d, mem_read_d, mem_write_d;
  logic [2:0]  mem_size_d;
  logic        branch_d, jump_d, lui_d, auipc_d, illegal_d;

  decode_ctrl_comb #(.ENABLE_M(ENABLE_M)) u_comb (
    .instr_i     (in_instr),
    .imm_o       (imm_d),
    .alu_ctrl_o  (alu_d),
    .regwrite_o  (regwrite_d),
    .imm_sel_o   (imm_sel_d),
    .mem_read_o  (mem_read_d),
    .mem_write_o (mem_write_d),
    .mem_size_o  (mem_size_d),
    .branch_o    (branch_d),
    .jump_o      (jump_d),
    .lui_o       (lui_d),
    .auipc_o     (auipc_d),
    .illegal_o   (illegal_d)
  );

  logic             valid_q;
  logic [XLEN-1:0]  pc_q, imm_q;
  logic [4:0]       rs1_q, rs2_q, rd_q, alu_q;
  logic             regwrite_q, imm_sel_q, mem_read_q, mem_write_q;
  logic [2:0]       mem_size_q;
  logic             branch_q, jump_q, lui_q, auipc_q, illegal_q;
  logic [CNT_W-1:0] cnt_q;
  logic             load;

  // Ready depends only on our own register and downstream, never on in_valid.
  assign in_ready = ~valid_q | out_ready;
  assign load     = in_valid & in_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      imm_q       <= '0;
      alu_q       <= ALU_INVALID;
      regwrite_q  <= 1'b0;
      imm_sel_q   <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_size_q  <= '0;
      branch_q    <= 1'b0;
      jump_q      <= 1'b0;
      lui_q       <= 1'b0;
      auipc_q     <= 1'b0;
      illegal_q   <= 1'b0;
      cnt_q       <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q     <= 1'b1;
      pc_q        <= in_pc;
      rs1_q       <= in_instr[19:15];
      rs2_q       <= in_instr[24:20];
      rd_q        <= in_instr[11:7];
      imm_q       <= imm_d;
      alu_q       <= alu_d;
      regwrite_q  <= regwrite_d;
      imm_sel_q   <= imm_sel_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_size_q  <= mem_size_d;
      branch_q    <= branch_d;
      jump_q      <= jump_d;
      lui_q       <= lui_d;
      auipc_q     <= auipc_d;
      illegal_q   <= illegal_d;
      if (illegal_d && cnt_q != {CNT_W{1'b1}})
        cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid     = valid_q;
  assign out_pc        = pc_q;
  assign out_rs1       = rs1_q;
  assign out_rs2       = rs2_q;
  assign out_rd        = rd_q;
  assign out_imm       = imm_q;
  assign out_alu_ctrl  = alu_q;
  assign out_regwrite  = regwrite_q;
  assign out_imm_sel   = imm_sel_q;
  assign out_mem_read  = mem_read_q;
  assign out_mem_write = mem_write_q;
  assign out_mem_size  = mem_size_q;
  assign out_branch    = branch_q;
  assign out_jump      = jump_q;
  assign out_lui       = lui_q;
  assign out_auipc     = auipc_q;
  assign out_illegal   = illegal_q;
  assign illegal_cnt   = cnt_q;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// tb/tb_decode_ctrl_stage.sv - self-checking bench for decode_ctrl_stage
module tb_decode_ctrl_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [4:0]  alu;
    logic        regwrite, imm_sel, mem_read, mem_write;
    logic [2:0]  mem_size;
    logic        branch, jump, lui, auipc, illegal;
  } bun_t;

  logic clk = 1'b0;
  logic rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  always #5 clk = ~clk;

  logic in_ready0, out_valid0, in_ready1, out_valid1;
  logic [31:0] pc0, imm0, pc1, imm1;
  logic [4:0]  rs1_0, rs2_0, rd_0, alu0, rs1_1, rs2_1, rd_1, alu1;
  logic        rw0, isel0, mr0, mw0, br0, jp0, lui0, aui0, ill0;
  logic        rw1, isel1, mr1, mw1, br1, jp1, lui1, aui1, ill1;
  logic [2:0]  ms0, ms1;
  logic [3:0]  cnt0;
  logic [15:0] cnt1;
  bun_t obs0, obs1;

  assign obs0 = {pc0, rs1_0, rs2_0, rd_0, imm0, alu0, rw0, isel0, mr0, mw0, ms0, br0, jp0, lui0, aui0, ill0};
  assign obs1 = {pc1, rs1_1, rs2_1, rd_1, imm1, alu1, rw1, isel1, mr1, mw1, ms1, br1, jp1, lui1, aui1, ill1};

  decode_ctrl_stage #(.XLEN(32), .ENABLE_M(1'b0), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid0), .out_ready(out_ready),
    .out_pc(pc0), .out_rs1(rs1_0), .out_rs2(rs2_0), .out_rd(rd_0), .out_imm(imm0),
    .out_alu_ctrl(alu0), .out_regwrite(rw0), .out_imm_sel(isel0), .out_mem_read(mr0),
    .out_mem_write(mw0), .out_mem_size(ms0), .out_branch(br0), .out_jump(jp0),
    .out_lui(lui0), .out_auipc(aui0), .out_illegal(ill0), .illegal_cnt(cnt0));

  decode_ctrl_stage #(.XLEN(32), .ENABLE_M(1'b1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid1), .out_ready(out_ready),
    .out_pc(pc1), .out_rs1(rs1_1), .out_rs2(rs2_1), .out_rd(rd_1), .out_imm(imm1),
    .out_alu_ctrl(alu1), .out_regwrite(rw1), .out_imm_sel(isel1), .out_mem_read(mr1),
    .out_mem_write(mw1), .out_mem_size(ms1), .out_branch(br1), .out_jump(jp1),
    .out_lui(lui1), .out_auipc(aui1), .out_illegal(ill1), .illegal_cnt(cnt1));

  int checks = 0;
  int failures = 0;

  bun_t exp_b[2];
  logic exp_v;
  int   exp_cnt[2];
  int   cmax[2] = '{15, 65535};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference decode written straight from the ISA rules with integer arithmetic.
  function automatic bun_t ref_decode(input logic [31:0] w, input logic [31:0] pc, input bit m);
    bun_t b;
    int s, op, f3, f7;
    int tbl[8] = '{2, 3, 8, 6, 7, 5, 1, 0};
    bit bad;
    s  = $signed(w);
    op = int'(w[6:0]);
    f3 = int'(w[14:12]);
    f7 = int'(w[31:25]);
    bad = 0;
    b = '0;
    b.pc  = pc;
    b.rs1 = w[19:15];
    b.rs2 = w[24:20];
    b.rd  = w[11:7];
    b.alu = 5'd2;
    case (op)
      'h33: begin
        b.regwrite = 1;
        if (f7 == 0) b.alu = 5'(tbl[f3]);
        else if (f7 == 'h20 && f3 == 0) b.alu = 5'd4;
        else if (f7 == 'h20 && f3 == 5) b.alu = 5'd9;
        else if (f7 == 1 && m) b.alu = 5'(16 + f3);
        else bad = 1;
      end
      'h13: begin
        b.imm = s >>> 20; b.imm_sel = 1; b.regwrite = 1; b.alu = 5'(tbl[f3]);
        if (f3 == 1 && f7 != 0) bad = 1;
        if (f3 == 5) begin
          if (f7 >= 32 && ((f7 / 32) % 2) == 1) b.alu = 5'd9;
          else if (f7 != 0) bad = 1;
        end
      end
      'h03: begin
        b.imm = s >>> 20; b.imm_sel = 1; b.regwrite = 1; b.mem_read = 1;
        b.mem_size = 3'(f3);
        bad = !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
      end
      'h23: begin
        b.imm = ((s >>> 25) << 5) | int'(w[11:7]); b.imm_sel = 1; b.mem_write = 1;
        b.mem_size = 3'(f3);
        bad = f3 > 2;
      end
      'h63: begin
        b.imm = ((s >>> 31) << 12) | (int'(w[7]) << 11) | (int'(w[30:25]) << 5) | (int'(w[11:8]) << 1);
        b.branch = 1; b.alu = 5'd4;
        bad = (f3 == 2 || f3 == 3);
      end
      'h6F: begin
        b.imm = ((s >>> 31) << 20) | (int'(w[19:12]) << 12) | (int'(w[20]) << 11) | (int'(w[30:21]) << 1);
        b.imm_sel = 1; b.jump = 1; b.regwrite = 1;
      end
      'h67: begin b.imm = s >>> 20; b.imm_sel = 1; b.jump = 1; b.regwrite = 1; end
      'h37: begin b.imm = w & 32'hFFFFF000; b.imm_sel = 1; b.regwrite = 1; b.lui = 1; end
      'h17: begin b.imm = w & 32'hFFFFF000; b.imm_sel = 1; b.regwrite = 1; b.auipc = 1; end
      default: bad = 1;
    endcase
    if (bad) begin
      b.illegal = 1; b.alu = 5'b01111;
      b.regwrite = 0; b.mem_read = 0; b.mem_write = 0; b.branch = 0; b.jump = 0;
    end
    if (w[11:7] == 5'd0) b.regwrite = 0;
    return b;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      exp_b[u] = '0;
      exp_b[u].alu = 5'b01111;
      exp_cnt[u] = 0;
    end
    exp_v = 0;
  endtask

  task automatic check_state();
    chk("out_valid0", out_valid0, exp_v);
    chk("out_valid1", out_valid1, exp_v);
    chk("bundle0", obs0, exp_b[0]);
    chk("bundle1", obs1, exp_b[1]);
    chk("illegal_cnt0", cnt0, exp_cnt[0]);
    chk("illegal_cnt1", cnt1, exp_cnt[1]);
  endtask

  // Starts just after a rising edge; returns 1 time unit after the next one.
  task automatic cycle(input logic v, input logic [31:0] w, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    bit acc;
    bun_t nb;
    in_valid = v; in_instr = w; in_pc = pc; out_ready = ordy; flush = fl;
    #2;
    chk("in_ready0", in_ready0, !exp_v || ordy);
    chk("in_ready1", in_ready1, !exp_v || ordy);
    acc = v && (!exp_v || ordy) && !fl;
    @(posedge clk);
    if (fl) exp_v = 0;
    else if (acc) begin
      for (int u = 0; u < 2; u++) begin
        nb = ref_decode(w, pc, u[0]);
        exp_b[u] = nb;
        if (nb.illegal && exp_cnt[u] < cmax[u]) exp_cnt[u]++;
      end
      exp_v = 1;
    end else if (ordy) exp_v = 0;
    #1;
    check_state();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0] opc [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};
    int k;
    w = $urandom;
    k = $urandom_range(0, 10);
    if (k < 10) w[6:0] = opc[k];
    if (w[6:0] == 7'h33 || w[6:0] == 7'h13) begin
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        2: w[31:25] = 7'h01;
        default: ;
      endcase
    end
    if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  initial begin
    rst_n = 0; flush = 0; in_valid = 0; out_ready = 0; in_instr = 0; in_pc = 0;
    model_reset();
    #12;
    chk("rst_in_ready0", in_ready0, 1'b1);
    check_state();
    rst_n = 1;
    @(posedge clk); #1;

    // Directed decodes
    cycle(1, 32'h002081B3, 32'h100, 1, 0);
    chk("add_alu", alu0, 5'b00010);
    cycle(1, 32'h402081B3, 32'h104, 1, 0);
    chk("sub_alu", alu0, 5'b00100);
    cycle(1, 32'h00812283, 32'h108, 1, 0);
    chk("lw_imm", imm0, 32'h00000008);
    cycle(1, 32'hFE512E23, 32'h10C, 1, 0);
    chk("sw_imm", imm0, 32'hFFFFFFFC);
    cycle(1, 32'h022081B3, 32'h110, 1, 0);
    chk("mul_m1_alu", alu1, 5'b10000);
    chk("mul_m0_cnt", cnt0, 4'd1);
    cycle(0, 32'h0, 32'h0, 1, 0);

    // Backpressure: load A, hold three cycles with B pending, then stream
    cycle(1, 32'h00500093, 32'h200, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 32'hFFFFFFFF, 32'h204, 0, 0);
    cycle(1, 32'hFFFFFFFF, 32'h204, 1, 0);
    cycle(1, 32'h123450B7, 32'h208, 1, 0);
    cycle(1, 32'h00001117, 32'h20C, 1, 0);
    cycle(1, 32'h0080006F, 32'h210, 1, 0);

    // Flush beats a simultaneous illegal load
    cycle(1, 32'hFFFFFFFF, 32'h300, 1, 1);

    // Asynchronous reset mid-stream
    cycle(1, 32'h002081B3, 32'h400, 0, 0);
    rst_n = 0;
    #1;
    model_reset();
    check_state();
    #3;
    rst_n = 1;
    @(posedge clk); #1;

    // Counter saturation on the 4-bit instance
    for (int i = 0; i < 18; i++) cycle(1, 32'hFFFFFFFF, 32'h500 + 4 * i, 1, 0);
    chk("cnt0_saturated", cnt0, 4'd15);

    // Random traffic against the reference model
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom,
            $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
